lzss_stream_ctrl: RTL and testbench
===================================

Name: lzss_stream_ctrl

Overview:
Sequencer that drives the LZSS encoder core from an on-chip source word memory and stores the encoder's codewords into a result memory. It fetches N 32-bit words, hands them to the encoder under its data_valid/busy handshake, and signals end of input with drop_done. It then drains codewords until the encoder's finish and reports completion, codeword total and timeout error to the host.

Parameters:
ADDR_W, 10, address width of the source word memory and the word counter
OUT_AW, 12, address width of the codeword result memory
TIMEOUT, 1024, max cycles in DRAIN without enc_out_valid or enc_finish before err is raised

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
start  in  1  one-cycle request to begin a job; ignored unless state is IDLE
word_count  in  ADDR_W+1  number of 32-bit words in the job, sampled on accepted start
src_rd  out  1  source memory read strobe
src_addr  out  ADDR_W  source memory word address
src_rdata  in  32  source read data, valid exactly 1 cycle after src_rd
enc_data  out  32  word presented to encoder
enc_data_valid  out  1  one-cycle strobe presenting enc_data
enc_drop_done  out  1  one-cycle strobe: no more input words
enc_busy  in  1  encoder cannot accept a word
enc_codeword  in  11  encoder output codeword
enc_out_valid  in  1  enc_codeword valid this cycle
enc_finish  in  1  encoder has emitted its last codeword
out_wr  out  1  result memory write strobe
out_addr  out  OUT_AW  result memory write address
out_wdata  out  11  codeword being written
cw_total  out  12  codewords written in current/last job
done  out  1  high in DONE until next accepted start
err  out  1  timeout flag, valid while done is high

Behaviour:
- Reset (async): state=IDLE; all outputs 0; internal counters 0; holding register cleared.
- States: IDLE, FETCH, WAIT_RD, PRESENT, DROP, DRAIN, DONE.
- IDLE: on start -> latch word_count into remaining, clear rd/wr pointers, cw_total, err; done=0. remaining==0 -> DROP, else FETCH.
- FETCH: src_rd=1, src_addr=rd_ptr for one cycle -> WAIT_RD.
- WAIT_RD: capture src_rdata into holding register; rd_ptr++, remaining-- -> PRESENT.
- PRESENT: while enc_busy=1 hold (no strobe, data held). First cycle with enc_busy=0: enc_data_valid=1 for that single cycle, word accepted. Then remaining>0 -> FETCH, else DROP. Throughput: max one word per 3 cycles.
- DROP: enc_drop_done=1 for one cycle -> DRAIN; drain timer cleared.
- DRAIN: timer increments each cycle; cleared by enc_out_valid. enc_finish -> DONE (err=0). Timer reaching TIMEOUT-1 without enc_finish -> DONE with err=1.
- DONE: done=1; start -> IDLE behaviour in same cycle (job restart); other inputs ignored.
- Codeword capture active in every state except IDLE and DONE: on enc_out_valid, the next cycle out_wr=1, out_addr=wr_ptr, out_wdata=registered codeword; wr_ptr++, cw_total++ (1-cycle latency, back-to-back valids produce back-to-back writes).
- Simultaneous enc_out_valid and enc_finish in DRAIN: the codeword is written (next cycle) and state goes to DONE; done asserts in the same cycle as that final out_wr.
- cw_total saturates at 4095; wr_ptr wraps modulo 2^OUT_AW; further writes still issued.
- enc_out_valid while in IDLE/DONE: discarded, no write.
- start while not IDLE/DONE: ignored, no effect on counters.
- Reset mid-job: immediate return to IDLE, no strobes asserted, in-flight word and codeword lost.
- enc_data_valid and enc_drop_done never asserted in the same cycle; drop_done exactly once per job.

Test Plan:
- word_count=3, enc_busy=0, encoder model emits 5 codewords then finish -> src_addr 0,1,2 read; 3 enc_data_valid strobes in order; one drop_done; out_addr 0..4 written; cw_total=5, done=1, err=0.
- enc_busy held high 10 cycles during PRESENT of word 1 -> enc_data stable, no strobe until busy falls, then exactly one strobe; no word duplicated or lost.
- word_count=0 -> no src_rd, drop_done 1 cycle after start acceptance, finish -> done, cw_total=0.
- TIMEOUT=16, encoder never finishes after drop_done -> done=1 with err=1 exactly 16 cycles after entering DRAIN; enc_out_valid pulses mid-drain restart the count.
- Final codeword coincident with enc_finish -> final out_wr performed, done asserted same cycle, cw_total includes it.
- Reset asserted mid-PRESENT, then start with word_count=2 -> outputs 0 during reset; new job starts from src_addr 0, out_addr 0, cw_total restarts at 0.

Source files
------------

// File: rtl/lzss_stream_ctrl.sv
// lzss_stream_ctrl: feeds source words from on-chip memory to the LZSS
// encoder, signals end of input, then drains codewords into a result memory
// until the encoder finishes or the drain timer expires.
module lzss_stream_ctrl #(
   parameter int ADDR_W  = 10,
   parameter int OUT_AW  = 12,
   parameter int TIMEOUT = 1024
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [ADDR_W:0]   word_count,
   output logic              src_rd,
   output logic [ADDR_W-1:0] src_addr,
   input  logic [31:0]       src_rdata,
   output logic [31:0]       enc_data,
   output logic              enc_data_valid,
   output logic              enc_drop_done,
   input  logic              enc_busy,
   input  logic [10:0]       enc_codeword,
   input  logic              enc_out_valid,
   input  logic              enc_finish,
   output logic              out_wr,
   output logic [OUT_AW-1:0] out_addr,
   output logic [10:0]       out_wdata,
   output logic [11:0]       cw_total,
   output logic              done,
   output logic              err
);

   localparam logic [2:0] IDLE    = 3'd0;
   localparam logic [2:0] FETCH   = 3'd1;
   localparam logic [2:0] WAIT_RD = 3'd2;
   localparam logic [2:0] PRESENT = 3'd3;
   localparam logic [2:0] DROP    = 3'd4;
   localparam logic [2:0] DRAIN   = 3'd5;
   localparam logic [2:0] DONE    = 3'd6;

   localparam int TW = $clog2(TIMEOUT) + 1;

   logic [2:0]        state;
   logic [ADDR_W:0]   remaining;
   logic [ADDR_W-1:0] rd_ptr;
   logic [OUT_AW-1:0] wr_ptr;
   logic [31:0]       hold;
   logic [TW-1:0]     timer;
   logic              accept;
   logic              cap_en;

   // A job can only be (re)started from IDLE or DONE; codewords are only
   // captured while a job is actually running.
   assign accept = start && (state == IDLE || state == DONE);
   assign cap_en = (state != IDLE) && (state != DONE);

   assign src_rd         = (state == FETCH);
   assign src_addr       = rd_ptr;
   assign enc_data       = hold;
   assign enc_data_valid = (state == PRESENT) && !enc_busy;
   assign enc_drop_done  = (state == DROP);
   assign done           = (state == DONE);

   // Job sequencer: fetch/present loop, end-of-input strobe, drain with timeout.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         remaining <= '0;
         rd_ptr    <= '0;
         hold      <= '0;
         timer     <= '0;
         err       <= 1'b0;
      end else begin
         case (state)
            IDLE, DONE: begin
               if (accept) begin
                  remaining <= word_count;
                  rd_ptr    <= '0;
                  err       <= 1'b0;
                  state     <= (word_count == '0) ? DROP : FETCH;
               end
            end
            FETCH: state <= WAIT_RD;
            WAIT_RD: begin
               hold      <= src_rdata;
               rd_ptr    <= rd_ptr + ADDR_W'(1);
               remaining <= remaining - (ADDR_W+1)'(1);
               state     <= PRESENT;
            end
            PRESENT: begin
               if (!enc_busy)
                  state <= (remaining != '0) ? FETCH : DROP;
            end
            DROP: begin
               timer <= '0;
               state <= DRAIN;
            end
            DRAIN: begin
               if (enc_finish) begin
                  err   <= 1'b0;
                  state <= DONE;
               end else if (enc_out_valid) begin
                  timer <= '0;
               end else if (timer == TW'(TIMEOUT - 1)) begin
                  err   <= 1'b1;
                  state <= DONE;
               end else begin
                  timer <= timer + TW'(1);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Codeword capture: register each valid codeword and write it one cycle later.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         out_wr    <= 1'b0;
         out_addr  <= '0;
         out_wdata <= '0;
         wr_ptr    <= '0;
         cw_total  <= '0;
      end else begin
         out_wr <= cap_en && enc_out_valid;
         if (accept) begin
            wr_ptr   <= '0;
            cw_total <= '0;
         end else if (cap_en && enc_out_valid) begin
            out_addr  <= wr_ptr;
            out_wdata <= enc_codeword;
            wr_ptr    <= wr_ptr + OUT_AW'(1);
            if (cw_total != 12'hFFF)
               cw_total <= cw_total + 12'd1;
         end
      end
   end

endmodule

// File: tb/tb_lzss_stream_ctrl.sv
// tb_lzss_stream_ctrl: directed jobs against a scoreboard; stimulus pushes the
// expected reads, encoder words, result writes and completion status, and a
// negedge monitor pops and compares whenever the controller presents them.
module tb_lzss_stream_ctrl;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [10:0] word_count;
   logic        src_rd;
   logic [9:0]  src_addr;
   logic [31:0] src_rdata;
   logic [31:0] enc_data;
   logic        enc_data_valid;
   logic        enc_drop_done;
   logic        enc_busy;
   logic [10:0] enc_codeword;
   logic        enc_out_valid;
   logic        enc_finish;
   logic        out_wr;
   logic [11:0] out_addr;
   logic [10:0] out_wdata;
   logic [11:0] cw_total;
   logic        done;
   logic        err;

   lzss_stream_ctrl #(.ADDR_W(10), .OUT_AW(12), .TIMEOUT(16)) dut (
      .clk(clk), .reset(reset), .start(start), .word_count(word_count),
      .src_rd(src_rd), .src_addr(src_addr), .src_rdata(src_rdata),
      .enc_data(enc_data), .enc_data_valid(enc_data_valid),
      .enc_drop_done(enc_drop_done), .enc_busy(enc_busy),
      .enc_codeword(enc_codeword), .enc_out_valid(enc_out_valid),
      .enc_finish(enc_finish), .out_wr(out_wr), .out_addr(out_addr),
      .out_wdata(out_wdata), .cw_total(cw_total), .done(done), .err(err)
   );

   always #5 clk = ~clk;

   logic [31:0] mem [0:3];

   // Source memory: data valid exactly one cycle after the read strobe.
   always @(posedge clk) begin
      if (src_rd) src_rdata <= mem[src_addr[1:0]];
      else        src_rdata <= 32'hDEAD_BEEF;
   end

   int vectors = 0;
   int miscompares = 0;
   int jobs = 0;
   int drops = 0;
   int strobes = 0;
   int exp_wr_addr = 0;

   logic [9:0]  exp_addr [$];
   logic [31:0] exp_enc  [$];
   logic [22:0] exp_wr   [$];
   logic [12:0] exp_done [$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Monitor: compare every presented transaction against the scoreboard.
   initial begin
      logic done_q;
      done_q = 1'b0;
      forever begin
         @(negedge clk);
         if (enc_data_valid && enc_drop_done) chk("strobe_exclusive", 1, 0);
         if (src_rd) begin
            if (exp_addr.size() == 0) chk("src_rd_unexpected", 32'(src_addr), 32'hFFFF);
            else chk("src_addr", 32'(src_addr), 32'(exp_addr.pop_front()));
         end
         if (enc_data_valid) begin
            strobes++;
            if (exp_enc.size() == 0) chk("enc_unexpected", enc_data, 32'hFFFF_FFFF);
            else chk("enc_data", enc_data, exp_enc.pop_front());
         end
         if (enc_drop_done) drops++;
         if (out_wr) begin
            if (exp_wr.size() == 0) chk("out_wr_unexpected", 32'({out_addr, out_wdata}), 32'hFFFF_FFFF);
            else chk("out_write", 32'({out_addr, out_wdata}), 32'(exp_wr.pop_front()));
         end
         if (done && !done_q) begin
            if (exp_done.size() == 0) chk("done_unexpected", 32'({cw_total, err}), 32'hFFFF_FFFF);
            else chk("done_status", 32'({cw_total, err}), 32'(exp_done.pop_front()));
         end
         done_q = done;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Issue a start; full=0 only expects the first read (job is aborted).
   task automatic start_job(input int n, input bit full);
      if (full) begin
         for (int i = 0; i < n; i++) begin
            exp_addr.push_back(10'(i));
            exp_enc.push_back(mem[i]);
         end
         jobs++;
      end else begin
         exp_addr.push_back(10'd0);
      end
      exp_wr_addr = 0;
      word_count  = 11'(n);
      start       = 1'b1;
      tick();
      start       = 1'b0;
   endtask

   task automatic emit_cw(input logic [10:0] cw);
      enc_out_valid = 1'b1;
      enc_codeword  = cw;
      exp_wr.push_back({12'(exp_wr_addr), cw});
      exp_wr_addr++;
      tick();
      enc_out_valid = 1'b0;
   endtask

   task automatic pulse_finish();
      enc_finish = 1'b1;
      tick();
      enc_finish = 1'b0;
   endtask

   task automatic wait_drop();
      int k;
      k = 0;
      while (!enc_drop_done && k < 200) begin tick(); k++; end
      if (!enc_drop_done) chk("wait_drop_timeout", 0, 1);
   endtask

   task automatic wait_done();
      int k;
      k = 0;
      while (!done && k < 200) begin tick(); k++; end
      chk("wait_done", 32'(done), 1);
   endtask

   task automatic wait_fetch(input logic [9:0] a);
      int k;
      k = 0;
      while (!(src_rd && src_addr == a) && k < 200) begin tick(); k++; end
      if (!(src_rd && src_addr == a)) chk("wait_fetch_timeout", 0, 1);
   endtask

   initial begin
      int s0;
      int k;
      mem[0] = 32'h1234_5678; mem[1] = 32'hCAFE_F00D;
      mem[2] = 32'h0BAD_BEEF; mem[3] = 32'h5555_AAAA;
      reset = 1'b1; start = 1'b0; word_count = '0; enc_busy = 1'b0;
      enc_codeword = '0; enc_out_valid = 1'b0; enc_finish = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_strobes", 32'({src_rd, enc_data_valid, enc_drop_done, out_wr, done, err}), 0);
      chk("rst_cw_total", 32'(cw_total), 0);
      chk("rst_enc_data", enc_data, 0);
      tick();
      reset = 1'b0;
      tick();

      // Basic job: three words, five codewords, then finish.
      start_job(3, 1);
      wait_drop();
      emit_cw(11'h001);
      emit_cw(11'h7FF);
      tick();
      emit_cw(11'h123);
      emit_cw(11'h456);
      emit_cw(11'h0AB);
      exp_done.push_back({12'd5, 1'b0});
      pulse_finish();
      wait_done();

      // Restart from DONE; hold busy during word 1, final codeword coincides with finish.
      start_job(3, 1);
      wait_fetch(10'd1);
      enc_busy = 1'b1;
      s0 = strobes;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (i == 3) begin
            enc_out_valid = 1'b1;
            enc_codeword  = 11'h155;
            exp_wr.push_back({12'(exp_wr_addr), 11'h155});
            exp_wr_addr++;
         end else begin
            enc_out_valid = 1'b0;
         end
      end
      chk("busy_hold_data", enc_data, mem[1]);
      chk("busy_no_strobe", 32'(strobes - s0), 0);
      enc_busy = 1'b0;
      wait_drop();
      tick();
      exp_done.push_back({12'd2, 1'b0});
      enc_out_valid = 1'b1; enc_codeword = 11'h2AA; enc_finish = 1'b1;
      exp_wr.push_back({12'(exp_wr_addr), 11'h2AA});
      exp_wr_addr++;
      tick();
      enc_out_valid = 1'b0; enc_finish = 1'b0;
      chk("final_wr_with_done", 32'({done, out_wr}), 32'b11);
      wait_done();

      // Empty job: drop_done right after start acceptance.
      start_job(0, 1);
      chk("empty_drop_done", 32'(enc_drop_done), 1);
      tick();
      exp_done.push_back({12'd0, 1'b0});
      pulse_finish();
      wait_done();

      // Timeout without activity: done 16 cycles after entering DRAIN.
      start_job(0, 1);
      exp_done.push_back({12'd0, 1'b1});
      k = 0;
      while (!done && k < 100) begin tick(); k++; end
      chk("timeout_cycles", 32'(k), 17);

      // Timeout with one codeword mid-drain restarting the count.
      start_job(0, 1);
      exp_done.push_back({12'd1, 1'b1});
      k = 0;
      while (!done && k < 100) begin
         tick(); k++;
         if (k == 6) begin
            enc_out_valid = 1'b1;
            enc_codeword  = 11'h0F0;
            exp_wr.push_back({12'(exp_wr_addr), 11'h0F0});
            exp_wr_addr++;
         end else begin
            enc_out_valid = 1'b0;
         end
      end
      enc_out_valid = 1'b0;
      chk("timeout_restart_cycles", 32'(k), 23);

      // Reset in PRESENT, then a fresh two-word job.
      enc_busy = 1'b1;
      start_job(2, 0);
      emit_cw(11'h333);
      repeat (4) tick();
      reset = 1'b1;
      @(negedge clk);
      chk("midrst_strobes", 32'({src_rd, enc_data_valid, enc_drop_done, out_wr, done, err}), 0);
      chk("midrst_counters", 32'({cw_total, src_addr}), 0);
      chk("midrst_data", enc_data, 0);
      tick();
      reset = 1'b0; enc_busy = 1'b0;
      tick();
      start_job(2, 1);
      emit_cw(11'h444);
      wait_drop();
      tick();
      exp_done.push_back({12'd1, 1'b0});
      pulse_finish();
      wait_done();

      repeat (3) tick();
      chk("queues_empty", 32'(exp_addr.size() + exp_enc.size() + exp_wr.size() + exp_done.size()), 0);
      chk("drop_per_job", 32'(drops), 32'(jobs));
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
